universal_sr_param: RTL and testbench

Parametrised successor to the 4-bit universal shift register. Generalised to WIDTH bits with an 8-mode control set: hold, logical shift, rotate, arithmetic shift right, parallel load, and a counted burst shift. The burst shift has a busy/done handshake. Sits between parallel datapaths and serial links (SPI-style framing, serialiser/deserialiser front ends).

---
 rtl/universal_sr_param.sv | 140 ++++++++++++++
 tb/tb_universal_sr_param.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/universal_sr_param.sv
// WIDTH-bit universal shift register with hold/shift/rotate/arith/load modes and a counted burst shift.
// Optional registered parity output enabled by defining UNIVERSAL_SR_PARITY_EN.
module universal_sr_param #(
    parameter  int WIDTH = 8,
    localparam int LW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_left,
    input  logic             sin_right,
    input  logic [WIDTH-1:0] d,
    input  logic [LW-1:0]    burst_len,
    input  logic             burst_dir,
    output logic [WIDTH-1:0] q,
    output logic             sout_right,
    output logic             sout_left,
    output logic             busy,
    output logic             done
`ifdef UNIVERSAL_SR_PARITY_EN
    ,
    output logic             parity
`endif
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] q_r, q_nxt_s;
    logic [LW-1:0]    count_r, count_nxt_s;
    logic             dir_r, dir_nxt_s;
    logic             done_r, done_nxt_s;

    // Requests longer than the register collapse to a full-width replacement.
    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
        if (len > LW'(WIDTH)) begin
            return LW'(WIDTH);
        end else begin
            return len;
        end
    endfunction

`ifdef UNIVERSAL_SR_PARITY_EN
    function automatic logic calc_parity(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    logic parity_r;
    assign parity = parity_r;
`endif

    assign q          = q_r;
    assign sout_right = q_r[0];
    assign sout_left  = q_r[WIDTH-1];
    assign busy       = (state_r == BURST);
    assign done       = done_r;

    // Next-state decode for register contents, burst control and completion pulse.
    always_comb begin
        q_nxt_s     = q_r;
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        dir_nxt_s   = dir_r;
        done_nxt_s  = 1'b0;
        if (en) begin
            case (state_r)
                IDLE: begin
                    case (mode)
                        3'b000: q_nxt_s = q_r;
                        3'b001: q_nxt_s = {sin_right, q_r[WIDTH-1:1]};
                        3'b010: q_nxt_s = {q_r[WIDTH-2:0], sin_left};
                        3'b011: q_nxt_s = d;
                        3'b100: q_nxt_s = {q_r[0], q_r[WIDTH-1:1]};
                        3'b101: q_nxt_s = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                        3'b110: q_nxt_s = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
                        3'b111: begin
                            if (burst_len != LW'(0)) begin
                                count_nxt_s = clamp_len(burst_len);
                                dir_nxt_s   = burst_dir;
                                state_nxt_s = BURST;
                            end else begin
                                state_nxt_s = IDLE;
                            end
                        end
                        default: q_nxt_s = q_r;
                    endcase
                end
                BURST: begin
                    if (dir_r) begin
                        q_nxt_s = {q_r[WIDTH-2:0], sin_left};
                    end else begin
                        q_nxt_s = {sin_right, q_r[WIDTH-1:1]};
                    end
                    count_nxt_s = count_r - LW'(1);
                    if (count_r == LW'(1)) begin
                        state_nxt_s = IDLE;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = BURST;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    count_nxt_s = LW'(0);
                end
            endcase
        end else begin
            // Stall: everything frozen, pulse cleared.
            done_nxt_s = 1'b0;
        end
    end

    // State registers; reset wins over any in-flight burst and suppresses done.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r     <= '0;
            state_r <= IDLE;
            count_r <= '0;
            dir_r   <= 1'b0;
            done_r  <= 1'b0;
`ifdef UNIVERSAL_SR_PARITY_EN
            parity_r <= 1'b0;
`endif
        end else begin
            q_r     <= q_nxt_s;
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            dir_r   <= dir_nxt_s;
            done_r  <= done_nxt_s;
`ifdef UNIVERSAL_SR_PARITY_EN
            parity_r <= calc_parity(q_nxt_s);
`endif
        end
    end

endmodule

// File: tb/tb_universal_sr_param.sv
// Scoreboard bench for universal_sr_param (WIDTH=8): driver queues hand-computed expectations,
// monitor pops one per clock and compares q, sout_*, busy, done (and parity when enabled).
module tb_universal_sr_param;

    localparam int WIDTH = 8;
    localparam int LW    = $clog2(WIDTH) + 1;

    logic             clk = 1'b0;
    logic             rst, en, sin_left, sin_right, burst_dir;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic [LW-1:0]    burst_len;
    logic [WIDTH-1:0] q;
    logic             sout_right, sout_left, busy, done;
`ifdef UNIVERSAL_SR_PARITY_EN
    logic             parity;
`endif

    universal_sr_param #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .sin_left(sin_left), .sin_right(sin_right), .d(d),
        .burst_len(burst_len), .burst_dir(burst_dir),
        .q(q), .sout_right(sout_right), .sout_left(sout_left),
        .busy(busy), .done(done)
`ifdef UNIVERSAL_SR_PARITY_EN
        , .parity(parity)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] q;
        logic             busy;
        logic             done;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: one expectation per clock, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, ".q"},    32'(q),          32'(e.q));
                check({e.name, ".busy"}, 32'(busy),       32'(e.busy));
                check({e.name, ".done"}, 32'(done),       32'(e.done));
                check({e.name, ".sr"},   32'(sout_right), 32'(e.q[0]));
                check({e.name, ".sl"},   32'(sout_left),  32'(e.q[WIDTH-1]));
`ifdef UNIVERSAL_SR_PARITY_EN
                check({e.name, ".par"},  32'(parity),     32'(^e.q));
`endif
            end
        end
    end

    task automatic step(input string name, input logic r, input logic e_n, input logic [2:0] m,
                        input logic [7:0] dd, input logic [LW-1:0] len, input logic dir,
                        input logic sl, input logic sr,
                        input logic [7:0] xq, input logic xb, input logic xd);
        exp_t e;
        @(negedge clk);
        rst = r; en = e_n; mode = m; d = dd; burst_len = len; burst_dir = dir;
        sin_left = sl; sin_right = sr;
        e.name = name; e.q = xq; e.busy = xb; e.done = xd;
        sb.push_back(e);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 3'd0; d = 8'h00; burst_len = '0; burst_dir = 1'b0;
        sin_left = 1'b0; sin_right = 1'b0;
        //      name      rst   en    mode    d      len     dir   sl    sr    q      busy  done
        step("reset",    1'b1, 1'b1, 3'd3, 8'hFF, 4'd0,  1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step("load_a5",  1'b0, 1'b1, 3'd3, 8'hA5, 4'd0,  1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0);
        step("shr",      1'b0, 1'b1, 3'd1, 8'h00, 4'd0,  1'b0, 1'b1, 1'b1, 8'hD2, 1'b0, 1'b0);
        step("shl",      1'b0, 1'b1, 3'd2, 8'h00, 4'd0,  1'b0, 1'b0, 1'b1, 8'hA4, 1'b0, 1'b0);
        step("asr",      1'b0, 1'b1, 3'd6, 8'h00, 4'd0,  1'b0, 1'b0, 1'b0, 8'hD2, 1'b0, 1'b0);
        step("rol",      1'b0, 1'b1, 3'd5, 8'h00, 4'd0,  1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0);
        step("ror",      1'b0, 1'b1, 3'd4, 8'h00, 4'd0,  1'b0, 1'b0, 1'b0, 8'hD2, 1'b0, 1'b0);
        step("hold",     1'b0, 1'b1, 3'd0, 8'hFF, 4'd0,  1'b0, 1'b1, 1'b1, 8'hD2, 1'b0, 1'b0);
        step("en_low",   1'b0, 1'b0, 3'd3, 8'hFF, 4'd0,  1'b0, 1'b1, 1'b1, 8'hD2, 1'b0, 1'b0);
        step("load_a4",  1'b0, 1'b1, 3'd3, 8'hA4, 4'd0,  1'b0, 1'b0, 1'b0, 8'hA4, 1'b0, 1'b0);
        // Left burst of 3 from zero with sin_left=1.
        step("load_00",  1'b0, 1'b1, 3'd3, 8'h00, 4'd0,  1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step("b3_start", 1'b0, 1'b1, 3'd7, 8'h00, 4'd3,  1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        step("b3_s1",    1'b0, 1'b1, 3'd3, 8'hEE, 4'd0,  1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
        step("b3_s2",    1'b0, 1'b1, 3'd3, 8'hEE, 4'd0,  1'b0, 1'b1, 1'b0, 8'h03, 1'b1, 1'b0);
        step("b3_s3",    1'b0, 1'b1, 3'd3, 8'hEE, 4'd0,  1'b0, 1'b1, 1'b0, 8'h07, 1'b0, 1'b1);
        step("b3_after", 1'b0, 1'b1, 3'd0, 8'h00, 4'd0,  1'b0, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);
        step("b0",       1'b0, 1'b1, 3'd7, 8'h00, 4'd0,  1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0);
        step("b0_after", 1'b0, 1'b1, 3'd0, 8'h00, 4'd0,  1'b0, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);
        // Clamped right burst: 15 -> 8 shifts, stream 1,0,1,1,0,0,1,0 replaces 0x07 with 0x4D.
        step("b15_start",1'b0, 1'b1, 3'd7, 8'h00, 4'd15, 1'b0, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0);
        step("b15_s1",   1'b0, 1'b1, 3'd3, 8'h55, 4'd1,  1'b1, 1'b0, 1'b1, 8'h83, 1'b1, 1'b0);
        step("b15_s2",   1'b0, 1'b1, 3'd3, 8'h55, 4'd1,  1'b1, 1'b1, 1'b0, 8'h41, 1'b1, 1'b0);
        step("b15_s3",   1'b0, 1'b1, 3'd3, 8'h55, 4'd1,  1'b1, 1'b0, 1'b1, 8'hA0, 1'b1, 1'b0);
        step("b15_s4",   1'b0, 1'b1, 3'd3, 8'h55, 4'd1,  1'b1, 1'b0, 1'b1, 8'hD0, 1'b1, 1'b0);
        step("b15_s5",   1'b0, 1'b1, 3'd3, 8'h55, 4'd1,  1'b1, 1'b1, 1'b0, 8'h68, 1'b1, 1'b0);
        step("b15_s6",   1'b0, 1'b1, 3'd3, 8'h55, 4'd1,  1'b1, 1'b1, 1'b0, 8'h34, 1'b1, 1'b0);
        step("b15_s7",   1'b0, 1'b1, 3'd3, 8'h55, 4'd1,  1'b1, 1'b0, 1'b1, 8'h9A, 1'b1, 1'b0);
        step("b15_s8",   1'b0, 1'b1, 3'd3, 8'h55, 4'd1,  1'b1, 1'b0, 1'b0, 8'h4D, 1'b0, 1'b1);
        // Left burst of 4 with a two-cycle stall after the first shift.
        step("st_load",  1'b0, 1'b1, 3'd3, 8'h00, 4'd0,  1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step("st_start", 1'b0, 1'b1, 3'd7, 8'h00, 4'd4,  1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        step("st_s1",    1'b0, 1'b1, 3'd0, 8'h00, 4'd0,  1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
        step("st_hold1", 1'b0, 1'b0, 3'd3, 8'hFF, 4'd0,  1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
        step("st_hold2", 1'b0, 1'b0, 3'd3, 8'hFF, 4'd0,  1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
        step("st_s2",    1'b0, 1'b1, 3'd0, 8'h00, 4'd0,  1'b0, 1'b1, 1'b0, 8'h03, 1'b1, 1'b0);
        step("st_s3",    1'b0, 1'b1, 3'd0, 8'h00, 4'd0,  1'b0, 1'b1, 1'b0, 8'h07, 1'b1, 1'b0);
        step("st_s4",    1'b0, 1'b1, 3'd0, 8'h00, 4'd0,  1'b0, 1'b1, 1'b0, 8'h0F, 1'b0, 1'b1);
        // Back-to-back: new right burst of 2 requested in the done cycle.
        step("bb_start", 1'b0, 1'b1, 3'd7, 8'h00, 4'd2,  1'b0, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b0);
        step("bb_s1",    1'b0, 1'b1, 3'd0, 8'h00, 4'd0,  1'b1, 1'b1, 1'b0, 8'h07, 1'b1, 1'b0);
        step("bb_s2",    1'b0, 1'b1, 3'd0, 8'h00, 4'd0,  1'b1, 1'b1, 1'b0, 8'h03, 1'b0, 1'b1);
        // Reset on the second burst cycle aborts without a done pulse.
        step("rb_start", 1'b0, 1'b1, 3'd7, 8'h00, 4'd3,  1'b1, 1'b0, 1'b0, 8'h03, 1'b1, 1'b0);
        step("rb_s1",    1'b0, 1'b1, 3'd0, 8'h00, 4'd0,  1'b0, 1'b0, 1'b0, 8'h06, 1'b1, 1'b0);
        step("rb_rst",   1'b1, 1'b1, 3'd0, 8'h00, 4'd0,  1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step("rb_after", 1'b0, 1'b1, 3'd0, 8'h00, 4'd0,  1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step("rb_after2",1'b0, 1'b1, 3'd0, 8'h00, 4'd0,  1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
